// File: rtl/ob_pkg.sv
// ob_pkg: shared order-book match types.
// Table entries, trade results and match/arbitration selectors.
package ob_pkg;

    typedef logic [15:0]        quantity_t;
    typedef logic signed [16:0] quantity_arith_t;
    typedef logic [15:0]        price_t;
    typedef logic [7:0]         uid_t;

    typedef enum logic [1:0] {
        MK_ASK_LM_BID = 2'd0,
        LM_ASK_MK_BID = 2'd1,
        MK_ASK_MK_BID = 2'd2
    } match_kind_t;

    typedef enum logic {
        ARB_FIXED = 1'b0,
        ARB_RR    = 1'b1
    } arb_mode_t;

    typedef struct packed {
        uid_t      uid;
        price_t    price;
        quantity_t quantity;
    } table_t;

    typedef struct packed {
        logic      mk_ask_lm_bid;
        logic      lm_ask_mk_bid;
        logic      mk_ask_mk_bid;
        logic      bid_consumed;
        logic      ask_consumed;
        uid_t      bid_uid;
        uid_t      ask_uid;
        price_t    bid_price;
        price_t    ask_price;
        quantity_t quantity;
        quantity_t remainder;
    } search_result_t;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ob_cntrl_match_if.sv
// ob_cntrl_match_if: channel heads in, trade query/result handshake out.
// master drives heads and query/ready; slave is the matcher.
interface ob_cntrl_match_if #(
    parameter int N_CH = 3
);
    import ob_pkg::*;

    localparam int IW = idx_w(N_CH);

    logic [N_CH-1:0]         ch_bid_vld_r;
    table_t [N_CH-1:0]       ch_bid_r;
    logic [N_CH-1:0]         ch_ask_vld_r;
    table_t [N_CH-1:0]       ch_ask_r;
    logic                    trade_qry;
    logic                    trade_busy;
    logic                    trade_vld_r;
    search_result_t          trade_r;
    logic [IW-1:0]           trade_ch_r;
    logic                    trade_rdy;
    logic                    trade_none_r;

    modport master (
        output ch_bid_vld_r, ch_bid_r, ch_ask_vld_r, ch_ask_r,
        output trade_qry, trade_rdy,
        input  trade_busy, trade_vld_r, trade_r, trade_ch_r,
        input  trade_none_r
    );

    modport slave (
        input  ch_bid_vld_r, ch_bid_r, ch_ask_vld_r, ch_ask_r,
        input  trade_qry, trade_rdy,
        output trade_busy, trade_vld_r, trade_r, trade_ch_r,
        output trade_none_r
    );

endinterface

// File: rtl/ob_match_arb.sv
// ob_match_arb: one-hot grant over N requests.
// Fixed priority from index 0, or rotating from a pointer that moves on advance.
module ob_match_arb
    import ob_pkg::*;
#(
    parameter int N  = 3,
    parameter int IW = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  arb_mode_t     mode_i,
    input  logic [N-1:0]  req_i,
    input  logic          adv_i,
    input  logic [IW-1:0] adv_idx_i,
    output logic [N-1:0]  gnt_o
);
    localparam int            IW1  = IW + 1;
    localparam logic [IW:0]   NW   = IW1'(N);
    localparam logic [IW-1:0] LAST = IW'(N - 1);

    logic [IW-1:0] ptr_q;
    logic [IW-1:0] ptr_d;
    logic [IW-1:0] base;
    logic [IW:0]   sum;
    logic [IW-1:0] idx;
    logic          found;

    assign base  = (mode_i == ARB_RR) ? ptr_q : '0;
    assign ptr_d = (adv_idx_i == LAST) ? '0 : adv_idx_i + IW'(1);

    // scan requests starting at base, wrapping, first hit wins
    always_comb begin
        gnt_o = '0;
        found = 1'b0;
        sum   = '0;
        idx   = '0;
        for (int k = 0; k < N; k++) begin
            sum = {1'b0, base} + IW1'(k);
            if (sum >= NW) sum = sum - NW;
            idx = sum[IW-1:0];
            if (!found && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

    // move the pointer past the accepted winner
    always_ff @(posedge clk) begin
        if (rst)        ptr_q <= '0;
        else if (adv_i) ptr_q <= ptr_d;
    end

endmodule

// File: rtl/ob_cntrl_match.sv
// ob_cntrl_match: snapshot bid/ask heads, pick one eligible channel,
// emit a registered trade result held until the consumer accepts it.
module ob_cntrl_match
    import ob_pkg::*;
#(
    parameter int          N_CH             = 3,
    parameter match_kind_t CH_KIND [N_CH]   = '{MK_ASK_LM_BID, LM_ASK_MK_BID, MK_ASK_MK_BID},
    parameter arb_mode_t   ARB_MODE         = ARB_FIXED
) (
    input logic             clk,
    input logic             rst,
    ob_cntrl_match_if.slave bus
);
    localparam int IW = idx_w(N_CH);
    localparam int QW = $bits(quantity_t);

    typedef enum logic [1:0] {IDLE, EVAL, DECIDE, HOLD} state_t;

    state_t                   state_q, state_d;
    logic [N_CH-1:0]          bid_vld_q, ask_vld_q;
    table_t [N_CH-1:0]        bid_q, ask_q;
    logic [N_CH-1:0]          elig_d, elig_q;
    quantity_arith_t [N_CH-1:0] dbid_d, dask_d, dbid_q, dask_q;
    logic [N_CH-1:0]          gnt;
    logic [IW-1:0]            win;
    logic                     any;
    logic                     accept;
    logic                     mkmk;
    table_t                   wb, wa;
    quantity_arith_t          wdb, wda;
    search_result_t           res_d, trade_q;
    logic                     trade_vld_q, trade_none_q;
    logic [IW-1:0]            trade_ch_q;

    assign accept = (state_q == HOLD) && bus.trade_rdy;

    // state register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.trade_qry) state_d = EVAL;
            EVAL:    state_d = DECIDE;
            DECIDE:  state_d = any ? HOLD : IDLE;
            HOLD:    if (bus.trade_rdy) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // capture all channel heads when a query is taken
    always_ff @(posedge clk) begin
        if (rst) begin
            bid_vld_q <= '0;
            ask_vld_q <= '0;
        end else if (state_q == IDLE && bus.trade_qry) begin
            bid_vld_q <= bus.ch_bid_vld_r;
            ask_vld_q <= bus.ch_ask_vld_r;
            bid_q     <= bus.ch_bid_r;
            ask_q     <= bus.ch_ask_r;
        end
    end

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        quantity_arith_t bq, aq;
        assign bq        = quantity_arith_t'({1'b0, bid_q[c].quantity});
        assign aq        = quantity_arith_t'({1'b0, ask_q[c].quantity});
        assign elig_d[c] = bid_vld_q[c] & ask_vld_q[c]
                         & (|bid_q[c].quantity) & (|ask_q[c].quantity);
        assign dbid_d[c] = bq - aq;
        assign dask_d[c] = aq - bq;
    end

    // register per-channel eligibility and quantity deltas
    always_ff @(posedge clk) begin
        if (state_q == EVAL) begin
            elig_q <= elig_d;
            dbid_q <= dbid_d;
            dask_q <= dask_d;
        end
    end

    ob_match_arb #(
        .N  (N_CH),
        .IW (IW)
    ) u_arb (
        .clk       (clk),
        .rst       (rst),
        .mode_i    (ARB_MODE),
        .req_i     (elig_q),
        .adv_i     (accept),
        .adv_idx_i (trade_ch_q),
        .gnt_o     (gnt)
    );

    // one-hot grant to channel index
    always_comb begin
        win = '0;
        for (int c = 0; c < N_CH; c++) begin
            if (gnt[c]) win = IW'(c);
        end
    end

    assign any  = |gnt;
    assign wb   = bid_q[win];
    assign wa   = ask_q[win];
    assign wdb  = dbid_q[win];
    assign wda  = dask_q[win];
    assign mkmk = (CH_KIND[win] == MK_ASK_MK_BID);

    // build the trade from the winning snapshot
    always_comb begin
        res_d           = '0;
        res_d.bid_uid   = wb.uid;
        res_d.ask_uid   = wa.uid;
        res_d.ask_price = wa.price;
        res_d.bid_price = mkmk ? wa.price : wb.price;
        if (!wdb[QW] && (|wdb)) begin
            res_d.ask_consumed = 1'b1;
            res_d.quantity     = wa.quantity;
            res_d.remainder    = wdb[QW-1:0];
        end else if (!wda[QW] && (|wda)) begin
            res_d.bid_consumed = 1'b1;
            res_d.quantity     = wb.quantity;
            res_d.remainder    = wda[QW-1:0];
        end else begin
            res_d.ask_consumed = 1'b1;
            res_d.bid_consumed = 1'b1;
            res_d.quantity     = wb.quantity;
        end
        case (CH_KIND[win])
            MK_ASK_LM_BID: res_d.mk_ask_lm_bid = 1'b1;
            LM_ASK_MK_BID: res_d.lm_ask_mk_bid = 1'b1;
            default:       res_d.mk_ask_mk_bid = 1'b1;
        endcase
    end

    // register the decision and hold it until accepted
    always_ff @(posedge clk) begin
        if (rst) begin
            trade_vld_q  <= 1'b0;
            trade_none_q <= 1'b0;
            trade_q      <= '0;
            trade_ch_q   <= '0;
        end else begin
            trade_none_q <= 1'b0;
            if (state_q == DECIDE) begin
                if (any) begin
                    trade_vld_q <= 1'b1;
                    trade_q     <= res_d;
                    trade_ch_q  <= win;
                end else begin
                    trade_none_q <= 1'b1;
                end
            end else if (accept) begin
                trade_vld_q <= 1'b0;
            end
        end
    end

    assign bus.trade_busy   = (state_q != IDLE);
    assign bus.trade_vld_r  = trade_vld_q;
    assign bus.trade_r      = trade_q;
    assign bus.trade_ch_r   = trade_ch_q;
    assign bus.trade_none_r = trade_none_q;

endmodule

// File: doc/ob_cntrl_match.md
OB_CNTRL_MATCH -- requirements
Module: ob_cntrl_match

Interface
REQ-001 Parameter N_CH, default 3: number of candidate bid/ask pairing channels (1..8).
REQ-002 Parameter CH_KIND[N_CH], default {MK_ASK_LM_BID, LM_ASK_MK_BID, MK_ASK_MK_BID}: per-channel match kind, type ob_pkg::match_kind_t.
REQ-003 Parameter ARB_MODE, default ARB_FIXED: ARB_FIXED (lowest channel index wins) or ARB_RR (round-robin), type ob_pkg::arb_mode_t.
REQ-004 clk  in  1  sole clock; rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 ch_bid_vld_r  in  N_CH  bid head valid per channel.
REQ-007 ch_bid_r  in  N_CH x ob_pkg::table_t  bid head entry per channel.
REQ-008 ch_ask_vld_r  in  N_CH  ask head valid per channel.
REQ-009 ch_ask_r  in  N_CH x ob_pkg::table_t  ask head entry per channel.
REQ-010 trade_qry  in  1  request one match evaluation.
REQ-011 trade_busy  out  1  evaluation in flight or result pending; queries ignored.
REQ-012 trade_vld_r  out  1  registered trade result valid.
REQ-013 trade_r  out  ob_pkg::search_result_t  trade result.
REQ-014 trade_ch_r  out  $clog2(N_CH) (min 1)  winning channel index.
REQ-015 trade_rdy  in  1  consumer accepts trade_r when trade_vld_r & trade_rdy.
REQ-016 trade_none_r  out  1  one-cycle pulse: query evaluated, no channel eligible.

Function
REQ-017 FSM states IDLE, EVAL, DECIDE, HOLD; trade_busy = (state != IDLE).
REQ-018 IDLE: trade_qry=1 snapshots all ch_* inputs into registers and moves to EVAL; trade_qry while busy is dropped, not queued.
REQ-019 EVAL (1 cycle): per channel register eligible = bid_vld & ask_vld & bid.quantity!=0 & ask.quantity!=0, plus signed deltas d_bid = bid.q - ask.q, d_ask = ask.q - bid.q in ob_pkg::quantity_arith_t (one bit wider than quantity_t); then DECIDE.
REQ-020 DECIDE: arbiter selects one eligible channel; winner registers trade_r/trade_ch_r, sets trade_vld_r, moves to HOLD; none eligible pulses trade_none_r, returns to IDLE.
REQ-021 Latency: qry accepted cycle t -> trade_vld_r or trade_none_r high at t+3.
REQ-022 HOLD: trade_vld_r, trade_r, trade_ch_r stable until trade_rdy=1; acceptance cycle returns to IDLE, trade_vld_r low next cycle; new query accepted no earlier than the following cycle.
REQ-023 Quantities: d_bid>0 -> ask_consumed=1, bid_consumed=0, quantity=ask.q, remainder=d_bid; d_ask>0 -> mirrored; equal -> both consumed, quantity=bid.q, remainder=0.
REQ-024 Price: MK_ASK_MK_BID uses snapshot ask.price for both ask_price and bid_price; other kinds report each side's own price.
REQ-025 trade_r kind flag (mk_ask_lm_bid / lm_ask_mk_bid / mk_ask_mk_bid) set from CH_KIND[winner], exactly one set; uid fields from the winning snapshot; unused fields zero.
REQ-026 ARB_FIXED: lowest eligible index wins.
REQ-027 ARB_RR: search starts at pointer; pointer becomes winner+1 (mod N_CH) only on acceptance; unchanged on trade_none_r.
REQ-028 Input changes after the snapshot do not affect the in-flight result.

Reset
REQ-029 rst forces state IDLE, trade_vld_r=0, trade_none_r=0, trade_r=0, trade_ch_r=0, RR pointer=0, snapshot discarded; applies mid-EVAL/DECIDE/HOLD with no result emitted.
REQ-030 trade_qry during the rst cycle is ignored.

Structure
REQ-031 ob_pkg holds match_kind_t, arb_mode_t, and reuses quantity_t, quantity_arith_t, table_t, search_result_t.
REQ-032 Sub-module ob_match_arb: N-bit request, one-hot grant, mode select, pointer register with advance enable.
REQ-033 Per-channel compare logic is one generate loop; no per-kind duplicated blocks.

Verification
REQ-034 Fixed, ch0 bid q=10 ask q=4 -> t+3 trade_ch_r=0, quantity=4, remainder=6, ask_consumed=1, bid_consumed=0.
REQ-035 ch2 (MK_MK) only, bid q=5 p=100, ask q=5 p=98 -> quantity=5, remainder=0, both consumed, both prices 98.
REQ-036 RR, all channels eligible, 4 queries each accepted immediately -> winners 0,1,2,0; trade_rdy held low 5 cycles -> outputs stable, next query dropped while busy.
REQ-037 All channels invalid or ch0 ask q=0 -> trade_none_r pulses at t+3, trade_vld_r stays 0, RR pointer unchanged.
REQ-038 rst asserted in DECIDE -> next cycle IDLE, trade_vld_r=0, no trade_none_r; ch0 inputs changed after snapshot -> result reflects snapshot values.
